// File: rtl/exp_arg_scaler.sv
// Exponent-argument scaler: x = -(delta * k) in q32.32, clamped to [-1.0, +1.0], feeding the
// exp LUT through a three-stage valid/ready pipeline with a global stall on back-pressure.
module exp_arg_scaler #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [63:0]      i_delta,
  input  logic [63:0]      i_k,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [63:0]      o_arg,
  output logic             o_sat_hi,
  output logic             o_sat_lo,
  output logic [CNT_W-1:0] o_sat_cnt
);

  localparam int unsigned W    = 64;
  localparam int unsigned FRAC = 32;

  localparam logic [W-1:0] PosOne = 64'h0000_0001_0000_0000;
  localparam logic [W-1:0] NegOne = 64'hFFFF_FFFF_0000_0000;
  localparam logic [W-1:0] IntMax = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] IntMin = 64'h8000_0000_0000_0000;

  logic             advance;
  logic             v1_q, v2_q, v3_q;
  logic [W-1:0]     delta_q, k_q;
  logic [2*W-1:0]   prod_q, prod_d;
  logic [W-1:0]     arg_q, arg_d;
  logic             hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fits;
  logic [W-1:0]     y, x;

  assign advance = !v3_q || i_ready;

  // Sign-extend both operands so the full 128-bit product is computed signed.
  assign prod_d = $signed({{W{delta_q[W-1]}}, delta_q}) * $signed({{W{k_q[W-1]}}, k_q});

  always_comb begin
    fits = (&prod_q[2*W-1:W+FRAC-1]) || (~|prod_q[2*W-1:W+FRAC-1]);
    y    = prod_q[W+FRAC-1:FRAC];
    if (!fits) y = prod_q[2*W-1] ? IntMin : IntMax;
    x    = (y == IntMin) ? IntMax : (~y + 64'd1);

    arg_d = x;
    hi_d  = 1'b0;
    lo_d  = 1'b0;
    if ($signed(x) > $signed(PosOne)) begin
      arg_d = PosOne;
      hi_d  = 1'b1;
    end else if ($signed(x) < $signed(NegOne)) begin
      arg_d = NegOne;
      lo_d  = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (v3_q && i_ready && (hi_q || lo_q) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      delta_q <= '0;
      k_q     <= '0;
      prod_q  <= '0;
      arg_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (advance) begin
        v1_q    <= i_valid;
        delta_q <= i_delta;
        k_q     <= i_k;
        v2_q    <= v1_q;
        prod_q  <= prod_d;
        v3_q    <= v2_q;
        arg_q   <= arg_d;
        hi_q    <= hi_d && v2_q;
        lo_q    <= lo_d && v2_q;
      end
    end
  end

  assign o_ready   = advance;
  assign o_valid   = v3_q;
  assign o_arg     = arg_q;
  assign o_sat_hi  = hi_q;
  assign o_sat_lo  = lo_q;
  assign o_sat_cnt = cnt_q;

endmodule

// File: tb/tb_exp_arg_scaler.sv
// Directed self-checking bench for exp_arg_scaler: arithmetic, clamping, stall and reset.
module tb_exp_arg_scaler;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready_blk;
  logic [63:0] delta;
  logic [63:0] kk;
  logic        out_valid;
  logic        ds_ready;
  logic [63:0] arg;
  logic        sat_hi;
  logic        sat_lo;
  logic [31:0] sat_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  exp_arg_scaler #(.CNT_W(32)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (in_valid),
    .o_ready   (out_ready_blk),
    .i_delta   (delta),
    .i_k       (kk),
    .o_valid   (out_valid),
    .i_ready   (ds_ready),
    .o_arg     (arg),
    .o_sat_hi  (sat_hi),
    .o_sat_lo  (sat_lo),
    .o_sat_cnt (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one sample into an empty pipeline with i_ready=1 and capture the result.
  task automatic run_one(input logic [63:0] d, input logic [63:0] k_in,
                         output logic [63:0] a, output logic h, output logic l,
                         output int lat);
    ds_ready = 1'b1;
    in_valid = 1'b1;
    delta    = d;
    kk       = k_in;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    a = arg;
    h = sat_hi;
    l = sat_lo;
    if (!out_valid) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; ds_ready = 1'b1; delta = '0; kk = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || arg !== 64'd0 || sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b arg=%h hi=%b lo=%b, want 0 0 0 0",
               out_valid, arg, sat_hi, sat_lo);
    end
    checks++;
    if (sat_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", sat_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_ready_blk !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", out_ready_blk);
    end
  endtask

  task automatic test_basic();
    logic [63:0] a; logic h, l; int lat;
    // 0.5 * 1.0 -> -0.5
    run_one(64'h0000_0000_8000_0000, 64'h0000_0001_0000_0000, a, h, l, lat);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL latency: got %0d extra cycles want 2", lat);
    end
    checks++;
    if (a !== 64'hFFFF_FFFF_8000_0000 || h !== 1'b0 || l !== 1'b0) begin
      errors++; $display("FAIL half: got %h hi=%b lo=%b want ffffffff80000000 0 0", a, h, l);
    end
    // -0.25 * 2.0 -> +0.5
    run_one(64'hFFFF_FFFF_C000_0000, 64'h0000_0002_0000_0000, a, h, l, lat);
    checks++;
    if (a !== 64'h0000_0000_8000_0000 || h !== 1'b0 || l !== 1'b0) begin
      errors++; $display("FAIL neg_delta: got %h hi=%b lo=%b want 0000000080000000 0 0", a, h, l);
    end
    // Exactly +1.0 is not a clamp
    run_one(64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, a, h, l, lat);
    checks++;
    if (a !== 64'h0000_0001_0000_0000 || h !== 1'b0 || l !== 1'b0) begin
      errors++; $display("FAIL exact_pos1: got %h hi=%b lo=%b want 0000000100000000 0 0", a, h, l);
    end
    // Exactly -1.0 is not a clamp
    run_one(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, a, h, l, lat);
    checks++;
    if (a !== 64'hFFFF_FFFF_0000_0000 || h !== 1'b0 || l !== 1'b0) begin
      errors++; $display("FAIL exact_neg1: got %h hi=%b lo=%b want ffffffff00000000 0 0", a, h, l);
    end
    // 1 LSB * 0.5: y truncates to 0
    run_one(64'h0000_0000_0000_0001, 64'h0000_0000_8000_0000, a, h, l, lat);
    checks++;
    if (a !== 64'd0) begin
      errors++; $display("FAIL trunc_pos: got %h want 0000000000000000", a);
    end
    // -1 LSB * 0.5: y floors to -1 LSB, x = +1 LSB
    run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_8000_0000, a, h, l, lat);
    checks++;
    if (a !== 64'h0000_0000_0000_0001) begin
      errors++; $display("FAIL trunc_neg: got %h want 0000000000000001", a);
    end
    checks++;
    if (sat_cnt !== 32'd0) begin
      errors++; $display("FAIL basic_cnt: got %0d want 0", sat_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [63:0] a; logic h, l; int lat;
    // 2.0 * 1.5 -> -3.0 clamps low
    run_one(64'h0000_0002_0000_0000, 64'h0000_0001_8000_0000, a, h, l, lat);
    checks++;
    if (a !== 64'hFFFF_FFFF_0000_0000 || h !== 1'b0 || l !== 1'b1) begin
      errors++; $display("FAIL sat_lo: got %h hi=%b lo=%b want ffffffff00000000 0 1", a, h, l);
    end
    checks++;
    if (sat_cnt !== 32'd1) begin
      errors++; $display("FAIL cnt_after_lo: got %0d want 1", sat_cnt);
    end
    // -3.0 * 1.0 -> +3.0 clamps high
    run_one(64'hFFFF_FFFD_0000_0000, 64'h0000_0001_0000_0000, a, h, l, lat);
    checks++;
    if (a !== 64'h0000_0001_0000_0000 || h !== 1'b1 || l !== 1'b0) begin
      errors++; $display("FAIL sat_hi: got %h hi=%b lo=%b want 0000000100000000 1 0", a, h, l);
    end
    // One LSB above +1.0 clamps
    run_one(64'hFFFF_FFFE_FFFF_FFFF, 64'h0000_0001_0000_0000, a, h, l, lat);
    checks++;
    if (a !== 64'h0000_0001_0000_0000 || h !== 1'b1 || l !== 1'b0) begin
      errors++; $display("FAIL just_over: got %h hi=%b lo=%b want 0000000100000000 1 0", a, h, l);
    end
    // Positive product overflow: y = INT64 max, x = -max -> clamps low
    run_one(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, a, h, l, lat);
    checks++;
    if (a !== 64'hFFFF_FFFF_0000_0000 || h !== 1'b0 || l !== 1'b1) begin
      errors++; $display("FAIL ovf_pos: got %h hi=%b lo=%b want ffffffff00000000 0 1", a, h, l);
    end
    // Negative overflow: y = INT64 min, negation gives INT64 max -> clamps high
    run_one(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, a, h, l, lat);
    checks++;
    if (a !== 64'h0000_0001_0000_0000 || h !== 1'b1 || l !== 1'b0) begin
      errors++; $display("FAIL ovf_neg: got %h hi=%b lo=%b want 0000000100000000 1 0", a, h, l);
    end
    exp_cnt = 5;
    checks++;
    if (sat_cnt !== 32'(exp_cnt)) begin
      errors++; $display("FAIL cnt_after_sat: got %0d want %0d", sat_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] din [8];
    logic [63:0] dexp [8];
    logic [63:0] prev_arg;
    logic        prev_hold;
    logic        acc, xfer;
    int in_idx, out_idx, stall_ready_bad, hold_bad, order_bad;
    // k = 1.0, delta = n/8 -> x = -n/8; the last (-1.0) is not a clamp
    din  = '{64'h0000_0000_2000_0000, 64'h0000_0000_4000_0000, 64'h0000_0000_6000_0000,
             64'h0000_0000_8000_0000, 64'h0000_0000_A000_0000, 64'h0000_0000_C000_0000,
             64'h0000_0000_E000_0000, 64'h0000_0001_0000_0000};
    dexp = '{64'hFFFF_FFFF_E000_0000, 64'hFFFF_FFFF_C000_0000, 64'hFFFF_FFFF_A000_0000,
             64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_6000_0000, 64'hFFFF_FFFF_4000_0000,
             64'hFFFF_FFFF_2000_0000, 64'hFFFF_FFFF_0000_0000};
    in_idx = 0; out_idx = 0; stall_ready_bad = 0; hold_bad = 0; order_bad = 0;
    prev_hold = 1'b0; prev_arg = '0;
    for (int cyc = 0; cyc < 60 && out_idx < 8; cyc++) begin
      ds_ready = !(cyc >= 5 && cyc <= 9);
      in_valid = (in_idx < 8);
      delta    = (in_idx < 8) ? din[in_idx] : 64'd0;
      kk       = 64'h0000_0001_0000_0000;
      #1;
      if (cyc >= 5 && cyc <= 9 && out_ready_blk !== 1'b0) stall_ready_bad++;
      if (prev_hold && (out_valid !== 1'b1 || arg !== prev_arg)) hold_bad++;
      acc  = in_valid && out_ready_blk;
      xfer = out_valid && ds_ready;
      if (xfer) begin
        if (arg !== dexp[out_idx] || sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
          order_bad++;
          $display("FAIL b2b_data[%0d]: got %h want %h", out_idx, arg, dexp[out_idx]);
        end
        out_idx++;
      end
      if (acc) in_idx++;
      prev_hold = out_valid && !ds_ready;
      prev_arg  = arg;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    ds_ready = 1'b1;
    checks++;
    if (stall_ready_bad != 0) begin
      errors++; $display("FAIL b2b_ready_stall: got %0d cycles ready high want 0", stall_ready_bad);
    end
    checks++;
    if (hold_bad != 0) begin
      errors++; $display("FAIL b2b_hold: got %0d unstable cycles want 0", hold_bad);
    end
    checks++;
    if (order_bad != 0) errors++;
    checks++;
    if (in_idx != 8 || out_idx != 8) begin
      errors++; $display("FAIL b2b_count: got in=%0d out=%0d want 8 8", in_idx, out_idx);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_no_dup: got valid=%b want 0", out_valid);
    end
    checks++;
    if (sat_cnt !== 32'(exp_cnt)) begin
      errors++; $display("FAIL b2b_cnt: got %0d want %0d", sat_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    ds_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      delta    = 64'h0000_0002_0000_0000;
      kk       = 64'h0000_0001_8000_0000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_inflight: got valid=%b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sat_cnt !== 32'd0 || arg !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b cnt=%0d arg=%h want 0 0 0", out_valid, sat_cnt, arg);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0 || sat_cnt !== 32'd0) begin
      errors++; $display("FAIL mid_stale: got %0d stale cycles cnt=%0d want 0 0", stale, sat_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
